ftrace_unit: RTL and testbench
==============================

# ftrace_unit

Hardware function-call tracer for the NPC core. It sits beside the commit stage and classifies each committed control-transfer instruction as call, return or tail jump. A parametrised shadow return-address stack tracks call depth and checks every return target. Events go into a buffered FIFO with a valid/ready handshake, so a DPI-C or debug consumer can drain them at its own rate without stalling the core.

## Interface
- XLEN, 32: PC/address width.
- RAS_DEPTH, 16: shadow stack entries, power of two, ≥2.
- FIFO_DEPTH, 8: event FIFO entries, power of two, ≥2.
- ALT_LINK, 1: 1 also treats x5 as a link register (RISC-V hint convention); 0 means x1 only.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- commit_valid  in  1  one instruction retires this cycle.
- commit_inst  in  32  retired instruction word.
- commit_pc  in  XLEN  PC of the retired instruction.
- commit_dnpc  in  XLEN  next PC actually taken.
- ev_valid  out  1  event available at FIFO head.
- ev_ready  in  1  consumer accepts head this cycle.
- ev_type  out  2  0=CALL, 1=RET, 2=TAIL.
- ev_pc  out  XLEN  commit_pc of the event.
- ev_target  out  XLEN  commit_dnpc of the event.
- ev_depth  out  $clog2(RAS_DEPTH+1)  stack depth after the event.
- ev_mismatch  out  1  RET target differed from the popped stack entry, or the stack was empty.
- sticky_ovf  out  1  a CALL occurred with the stack full.
- sticky_udf  out  1  a RET occurred with the stack empty.
- drop_cnt  out  16  events lost to a full FIFO; saturates at 0xFFFF.

## Operation
- Link register set: L = {x1}, plus x5 when ALT_LINK=1.
- Decode is qualified by commit_valid. JAL is opcode 1101111. JALR is opcode 1100111 with funct3=000.
- CALL: JAL or JALR with rd ∈ L. Push commit_pc+4 (XLEN wrap), depth+1.
- RET: JALR with rd=x0, rs1 ∈ L and imm=0. Pop the top entry, depth−1, set mismatch = (popped ≠ commit_dnpc).
- TAIL: JALR with rd=x0 that is not a RET. No stack change.
- Everything else is ignored.
- JALR with rd ∈ L and rs1 ∈ L is treated as CALL (no pop-then-push).
- Stack is circular, with top pointer and depth counter.
  - CALL when full: overwrite the oldest entry. Depth stays RAS_DEPTH. Set sticky_ovf.
  - RET when empty: no pop. Depth stays 0. ev_mismatch=1. Set sticky_udf.
- Every classified instruction produces one event. ev_depth holds the post-update depth.
- FIFO full:
  - With ev_ready=0, the incoming event is discarded and drop_cnt increments.
  - With ev_ready=1, pop and push happen together and nothing is dropped.
- Stack update is independent of FIFO state. Dropped events still update the stack.
- Sticky flags and drop_cnt clear only on rst.

## Timing
- Reset values: ev_valid=0, ev_type=0, ev_pc=0, ev_target=0, ev_depth=0, ev_mismatch=0, sticky_ovf=0, sticky_udf=0, drop_cnt=0. Stack pointer, depth and FIFO pointers are 0.
- Latency: an event committed in cycle N appears at the FIFO head no earlier than cycle N+1. With an empty FIFO, ev_valid rises exactly at N+1.
- Handshake:
  - The head transfers when ev_valid && ev_ready.
  - ev_* stay stable while ev_valid=1 and ev_ready=0.
  - ev_valid does not depend combinationally on ev_ready.
- Back-to-back commits are sustained at one per cycle. Stack state from cycle N is visible to the decode in cycle N+1 with no bubble.
- Reset asserted mid-operation empties the stack and FIFO immediately (asynchronous). Events in flight are lost and not counted in drop_cnt.

## Structure
- ftrace_pkg holds:
  - ev_type_e enum {EV_CALL, EV_RET, EV_TAIL}.
  - Opcode constants OP_JAL=7'b1101111 and OP_JALR=7'b1100111.
  - Packed struct ftrace_ev_t {type, pc, target, depth, mismatch}.
- Sub-module ftrace_fifo: a generic synchronous FIFO of ftrace_ev_t, parameterised by FIFO_DEPTH, exposing push/full and valid/ready/pop.
- Decode, stack and counters live in ftrace_unit itself.

## Test plan
- Call then return: CALL at pc 0x80000000 (jal x1), then RET with dnpc 0x80000004. Expect events CALL depth 1, then RET depth 0 with mismatch=0.
- Bad return: CALL at 0x80000010, then RET with dnpc 0x80000100. Expect RET with mismatch=1 and depth 0.
- Overflow: RAS_DEPTH=4, 5 CALLs at pcs 0x100, 0x200, 0x300, 0x400, 0x500, then 4 RETs with correct dnpcs 0x504, 0x404, 0x304, 0x204. Expect sticky_ovf=1, no mismatches, final depth 0.
- Underflow: a RET after reset. Expect an event with depth 0, mismatch=1 and sticky_udf=1.
- Backpressure: FIFO_DEPTH=4, ev_ready=0, 6 TAIL commits (jalr x0, 8(x6)). Expect 4 buffered events with stable outputs, drop_cnt=2, and in-order drain once ev_ready=1.
- ALT_LINK=0: jalr x5 as a call produces no CALL event. With ALT_LINK=1, the same instruction produces CALL depth 1.

Source files
------------

// File: rtl/ftrace_pkg.sv
// ftrace_pkg: shared types and constants for the function-call tracer.
//   ev_type_e    - event classification carried in every trace event
//   OP_JAL/JALR  - RV32 opcodes used by the commit-stage decoder
//   ftrace_ev_t  - packed event record at the default 32-bit geometry
//   is_link()    - link-register test with optional x5 alternate link
package ftrace_pkg;

  localparam int DEF_XLEN      = 32;
  localparam int DEF_RAS_DEPTH = 16;
  localparam int DEF_DEPTH_W   = $clog2(DEF_RAS_DEPTH + 1);

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [2:0] F3_JALR = 3'b000;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [4:0] REG_RA = 5'd1;
  localparam logic [4:0] REG_T0 = 5'd5;

  typedef enum logic [1:0] {
    EV_CALL = 2'd0,
    EV_RET  = 2'd1,
    EV_TAIL = 2'd2
  } ev_type_e;

  typedef struct packed {
    ev_type_e                 ev_type;
    logic [DEF_XLEN-1:0]      pc;
    logic [DEF_XLEN-1:0]      target;
    logic [DEF_DEPTH_W-1:0]   depth;
    logic                     mismatch;
  } ftrace_ev_t;

  // x1 is always a link register; x5 only when the alternate link is enabled.
  function automatic logic is_link(input logic [4:0] r, input logic alt);
    is_link = (r == REG_RA) || (alt && (r == REG_T0));
  endfunction

endpackage

// File: rtl/ftrace_fifo.sv
// ftrace_fifo: synchronous FIFO of trace events.
//   clk, rst        - clock, asynchronous active-high reset
//   push, push_data - write side; a push while full is accepted only when
//                     the head pops in the same cycle
//   full            - all FIFO_DEPTH entries occupied
//   valid, ready    - head handshake; head transfers on valid && ready
//   head            - event at the FIFO head, stable until it transfers
module ftrace_fifo
  import ftrace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter type ev_t = ftrace_ev_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  ev_t  push_data,
  output logic full,
  output logic valid,
  input  logic ready,
  output ev_t  head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  ev_t           mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign valid = (count != '0);
  assign full  = (count == FULL_CNT);
  assign head  = mem[rd_ptr];

  // Handshake qualification; a full FIFO still accepts when the head leaves.
  always_comb begin
    do_pop  = valid && ready;
    do_push = push && (!full || do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ftrace_unit.sv
// ftrace_unit: commit-stage function-call tracer.
//   clk, rst                      - clock, asynchronous active-high reset
//   commit_valid/inst/pc/dnpc     - retired instruction and its real next PC
//   ev_valid, ev_ready            - event FIFO head handshake
//   ev_type/pc/target/depth/mismatch - head event contents
//   sticky_ovf, sticky_udf        - shadow stack overflow / underflow seen
//   drop_cnt                      - saturating count of events lost to a full FIFO
// Calls push the return address on a circular shadow stack, returns pop and
// compare it against the real target, tail jumps are only reported.
module ftrace_unit
  import ftrace_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RAS_DEPTH  = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int ALT_LINK   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           commit_valid,
  input  logic [31:0]                    commit_inst,
  input  logic [XLEN-1:0]                commit_pc,
  input  logic [XLEN-1:0]                commit_dnpc,
  output logic                           ev_valid,
  input  logic                           ev_ready,
  output logic [1:0]                     ev_type,
  output logic [XLEN-1:0]                ev_pc,
  output logic [XLEN-1:0]                ev_target,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ev_depth,
  output logic                           ev_mismatch,
  output logic                           sticky_ovf,
  output logic                           sticky_udf,
  output logic [15:0]                    drop_cnt
);

  localparam int DEPTH_W = $clog2(RAS_DEPTH + 1);
  localparam int PW      = $clog2(RAS_DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(RAS_DEPTH);
  localparam logic [PW-1:0]      PTR_ONE    = PW'(1);
  localparam logic [XLEN-1:0]    LINK_OFS   = XLEN'(4);
  localparam logic               ALT        = (ALT_LINK != 0);

  typedef struct packed {
    ev_type_e             ev_type;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      target;
    logic [DEPTH_W-1:0]   depth;
    logic                 mismatch;
  } ev_t;

  // Decode fields
  logic [6:0]  opcode_s;
  logic [4:0]  rd_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_s;
  logic [11:0] imm_s;
  logic        is_jal_s;
  logic        is_jalr_s;
  logic        is_call_s;
  logic        is_ret_s;
  logic        is_tail_s;

  // Shadow stack: top_r is the next write slot, so when full it also
  // addresses the oldest entry, which a further call overwrites.
  logic [XLEN-1:0]    ras_r [RAS_DEPTH];
  logic [PW-1:0]      top_r;
  logic [DEPTH_W-1:0] depth_r;
  logic [PW-1:0]      top_m1_s;
  logic [XLEN-1:0]    popped_s;
  logic               stack_full_s;
  logic               stack_empty_s;
  logic [DEPTH_W-1:0] depth_next_s;
  logic               mismatch_s;

  // Event path
  ev_t  ev_in_s;
  ev_t  head_s;
  logic ev_push_s;
  logic fifo_full_s;
  logic drop_s;

  // Instruction classification. JALR with rd and rs1 both links is a call.
  always_comb begin
    opcode_s  = commit_inst[6:0];
    rd_s      = commit_inst[11:7];
    funct3_s  = commit_inst[14:12];
    rs1_s     = commit_inst[19:15];
    imm_s     = commit_inst[31:20];
    is_jal_s  = (opcode_s == OP_JAL);
    is_jalr_s = (opcode_s == OP_JALR) && (funct3_s == F3_JALR);
    is_call_s = commit_valid && (is_jal_s || is_jalr_s) && is_link(rd_s, ALT);
    is_ret_s  = commit_valid && is_jalr_s && (rd_s == REG_X0) &&
                is_link(rs1_s, ALT) && (imm_s == 12'd0);
    is_tail_s = commit_valid && is_jalr_s && (rd_s == REG_X0) && !is_ret_s;
  end

  // Stack bookkeeping for this cycle's commit.
  always_comb begin
    stack_full_s  = (depth_r == FULL_DEPTH);
    stack_empty_s = (depth_r == '0);
    top_m1_s      = top_r - PTR_ONE;
    popped_s      = ras_r[top_m1_s];
    depth_next_s  = depth_r;
    mismatch_s    = 1'b0;
    if (is_call_s) begin
      depth_next_s = stack_full_s ? depth_r : (depth_r + DEPTH_ONE);
    end else if (is_ret_s) begin
      depth_next_s = stack_empty_s ? depth_r : (depth_r - DEPTH_ONE);
      mismatch_s   = stack_empty_s || (popped_s != commit_dnpc);
    end else begin
      depth_next_s = depth_r;
    end
  end

  // Event record and drop detection.
  always_comb begin
    ev_in_s          = '0;
    ev_in_s.pc       = commit_pc;
    ev_in_s.target   = commit_dnpc;
    ev_in_s.depth    = depth_next_s;
    ev_in_s.mismatch = mismatch_s;
    if (is_call_s) begin
      ev_in_s.ev_type = EV_CALL;
    end else if (is_ret_s) begin
      ev_in_s.ev_type = EV_RET;
    end else begin
      ev_in_s.ev_type = EV_TAIL;
    end
    ev_push_s = is_call_s || is_ret_s || is_tail_s;
    drop_s    = ev_push_s && fifo_full_s && !ev_ready;
  end

  // Shadow stack state; updated whether or not the event fits the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_r[i] <= '0;
      end
      top_r   <= '0;
      depth_r <= '0;
    end else begin
      if (is_call_s) begin
        ras_r[top_r] <= commit_pc + LINK_OFS;
        top_r        <= top_r + PTR_ONE;
      end else if (is_ret_s && !stack_empty_s) begin
        top_r <= top_m1_s;
      end
      depth_r <= depth_next_s;
    end
  end

  // Sticky error flags and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_udf <= 1'b0;
      drop_cnt   <= 16'd0;
    end else begin
      if (is_call_s && stack_full_s) begin
        sticky_ovf <= 1'b1;
      end
      if (is_ret_s && stack_empty_s) begin
        sticky_udf <= 1'b1;
      end
      if (drop_s && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  ftrace_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ev_t       (ev_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ev_push_s),
    .push_data (ev_in_s),
    .full      (fifo_full_s),
    .valid     (ev_valid),
    .ready     (ev_ready),
    .head      (head_s)
  );

  assign ev_type     = head_s.ev_type;
  assign ev_pc       = head_s.pc;
  assign ev_target   = head_s.target;
  assign ev_depth    = head_s.depth;
  assign ev_mismatch = head_s.mismatch;

endmodule

// File: tb/tb_ftrace_unit.sv
// tb_ftrace_unit: scoreboard bench for ftrace_unit.
// dut0: RAS_DEPTH=4, FIFO_DEPTH=4, ALT_LINK=1 (fully modelled).
// dut1: defaults with ALT_LINK=0 (checked only for x5 link handling).
module tb_ftrace_unit;

  localparam int CL_CALL = 0;
  localparam int CL_RET  = 1;
  localparam int CL_TAIL = 2;
  localparam int CL_IGN  = 3;

  localparam logic [31:0] I_JAL_RA   = 32'h000000EF; // jal x1
  localparam logic [31:0] I_RET_RA   = 32'h00008067; // jalr x0,0(x1)
  localparam logic [31:0] I_CALL_X5  = 32'h000302E7; // jalr x5,0(x6)
  localparam logic [31:0] I_TAIL8    = 32'h00830067; // jalr x0,8(x6)

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_valid = 1'b0;
  logic [31:0] commit_inst  = 32'd0;
  logic [31:0] commit_pc    = 32'd0;
  logic [31:0] commit_dnpc  = 32'd0;
  logic        ev_ready     = 1'b0;

  logic        ev_valid, ev_mismatch, sticky_ovf, sticky_udf;
  logic [1:0]  ev_type;
  logic [31:0] ev_pc, ev_target;
  logic [2:0]  ev_depth;
  logic [15:0] drop_cnt;

  logic        d1_valid, d1_mismatch, d1_ovf, d1_udf;
  logic [1:0]  d1_type;
  logic [31:0] d1_pc, d1_target;
  logic [4:0]  d1_depth;
  logic [15:0] d1_drop;

  typedef struct packed {
    logic [1:0]  t;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [2:0]  depth;
    logic        mm;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mstack[$];
  logic        m_ovf, m_udf;
  int          exp_drop;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  ftrace_unit #(.XLEN(32), .RAS_DEPTH(4), .FIFO_DEPTH(4), .ALT_LINK(1)) dut0 (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_inst(commit_inst),
    .commit_pc(commit_pc), .commit_dnpc(commit_dnpc), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_type(ev_type), .ev_pc(ev_pc), .ev_target(ev_target),
    .ev_depth(ev_depth), .ev_mismatch(ev_mismatch), .sticky_ovf(sticky_ovf),
    .sticky_udf(sticky_udf), .drop_cnt(drop_cnt)
  );

  ftrace_unit #(.XLEN(32), .RAS_DEPTH(16), .FIFO_DEPTH(8), .ALT_LINK(0)) dut1 (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_inst(commit_inst),
    .commit_pc(commit_pc), .commit_dnpc(commit_dnpc), .ev_valid(d1_valid),
    .ev_ready(ev_ready), .ev_type(d1_type), .ev_pc(d1_pc), .ev_target(d1_target),
    .ev_depth(d1_depth), .ev_mismatch(d1_mismatch), .sticky_ovf(d1_ovf),
    .sticky_udf(d1_udf), .drop_cnt(d1_drop)
  );

  // Scoreboard: every dut0 head transfer is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ev_valid && ev_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: got type=%0d pc=%h target=%h, required no event",
                 ev_type, ev_pc, ev_target);
      end else begin
        mon_e = exp_q.pop_front();
        if ({ev_type, ev_pc, ev_target, ev_depth, ev_mismatch} !==
            {mon_e.t, mon_e.pc, mon_e.tgt, mon_e.depth, mon_e.mm}) begin
          n_errors++;
          $display("FAIL event: got type=%0d pc=%h tgt=%h depth=%0d mm=%0d, required type=%0d pc=%h tgt=%h depth=%0d mm=%0d",
                   ev_type, ev_pc, ev_target, ev_depth, ev_mismatch,
                   mon_e.t, mon_e.pc, mon_e.tgt, mon_e.depth, mon_e.mm);
        end
      end
    end
  end

  // Present one commit for one cycle; model the stack and FIFO acceptance.
  task automatic drive_commit(input logic v, input logic [31:0] inst, input int cls,
                              input logic [31:0] pc, input logic [31:0] dnpc);
    exp_t        e;
    logic [31:0] top;
    commit_valid = v;
    commit_inst  = inst;
    commit_pc    = pc;
    commit_dnpc  = dnpc;
    if (v && cls != CL_IGN) begin
      e     = '0;
      e.pc  = pc;
      e.tgt = dnpc;
      case (cls)
        CL_CALL: begin
          if (mstack.size() == 4) begin
            top   = mstack.pop_front();
            m_ovf = 1'b1;
          end
          mstack.push_back(pc + 32'd4);
          e.t = 2'd0;
        end
        CL_RET: begin
          e.t = 2'd1;
          if (mstack.size() == 0) begin
            e.mm  = 1'b1;
            m_udf = 1'b1;
          end else begin
            top  = mstack.pop_back();
            e.mm = (top != dnpc);
          end
        end
        default: e.t = 2'd2;
      endcase
      e.depth = 3'(mstack.size());
      if (exp_q.size() < 4 || ev_ready) exp_q.push_back(e);
      else exp_drop++;
    end
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    commit_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Let the consumer drain; bounded wait, then FIFO must be empty.
  task automatic wait_drain();
    int budget = 200;
    ev_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    idle(1);
    n_checks++;
    if (exp_q.size() != 0 || ev_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL drain: got pending=%0d ev_valid=%0b, required pending=0 ev_valid=0",
               exp_q.size(), ev_valid);
    end
  endtask

  // Asynchronous reset, checked before any clock edge.
  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if ({ev_valid, ev_type, ev_pc, ev_target, ev_depth, ev_mismatch, sticky_ovf, sticky_udf, drop_cnt} !== '0) begin
      n_errors++;
      $display("FAIL reset: got valid=%0b type=%0d pc=%h tgt=%h depth=%0d mm=%0b ovf=%0b udf=%0b drop=%0d, required all 0",
               ev_valid, ev_type, ev_pc, ev_target, ev_depth, ev_mismatch, sticky_ovf, sticky_udf, drop_cnt);
    end
    exp_q.delete();
    mstack.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    exp_drop = 0;
    commit_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_call_ret();
    ev_ready = 1'b1;
    drive_commit(1'b1, I_JAL_RA, CL_CALL, 32'h80000000, 32'h80000100);
    @(negedge clk);
    n_checks++;
    if (ev_valid !== 1'b1 || ev_depth !== 3'd1) begin
      n_errors++;
      $display("FAIL call_latency: got valid=%0b depth=%0d, required valid=1 depth=1", ev_valid, ev_depth);
    end
    @(posedge clk);
    #1;
    drive_commit(1'b1, I_RET_RA, CL_RET, 32'h80000100, 32'h80000004);
    drive_commit(1'b1, I_JAL_RA, CL_CALL, 32'h80000010, 32'h80000200);
    drive_commit(1'b1, I_RET_RA, CL_RET, 32'h80000200, 32'h80000100);
    drive_commit(1'b1, I_JAL_RA, CL_CALL, 32'hFFFFFFFC, 32'h00000040);
    drive_commit(1'b1, I_RET_RA, CL_RET, 32'h00000040, 32'h00000000);
    wait_drain();
    n_checks++;
    if (sticky_ovf !== 1'b0 || sticky_udf !== 1'b0) begin
      n_errors++;
      $display("FAIL call_ret_sticky: got ovf=%0b udf=%0b, required 0 0", sticky_ovf, sticky_udf);
    end
  endtask

  task automatic test_overflow();
    ev_ready = 1'b1;
    for (int i = 1; i <= 5; i++) drive_commit(1'b1, I_JAL_RA, CL_CALL, 32'(i * 256), 32'h9000);
    for (int i = 5; i >= 2; i--) drive_commit(1'b1, I_RET_RA, CL_RET, 32'h9000, 32'(i * 256 + 4));
    wait_drain();
    n_checks++;
    if (sticky_ovf !== 1'b1 || sticky_udf !== 1'b0) begin
      n_errors++;
      $display("FAIL overflow_sticky: got ovf=%0b udf=%0b, required 1 0", sticky_ovf, sticky_udf);
    end
  endtask

  task automatic test_underflow();
    ev_ready = 1'b1;
    drive_commit(1'b1, I_RET_RA, CL_RET, 32'h00000700, 32'h00000800);
    wait_drain();
    n_checks++;
    if (sticky_udf !== 1'b1 || sticky_ovf !== 1'b0) begin
      n_errors++;
      $display("FAIL underflow_sticky: got udf=%0b ovf=%0b, required 1 0", sticky_udf, sticky_ovf);
    end
  endtask

  task automatic test_backpressure();
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++)
      drive_commit(1'b1, I_TAIL8, CL_TAIL, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 16));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (ev_valid !== 1'b1 || ev_type !== 2'd2 || ev_pc !== 32'h1000 || ev_target !== 32'h2000) begin
        n_errors++;
        $display("FAIL bp_stable: got valid=%0b type=%0d pc=%h tgt=%h, required 1 2 00001000 00002000",
                 ev_valid, ev_type, ev_pc, ev_target);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (drop_cnt !== 16'd2 || exp_drop != 2) begin
      n_errors++;
      $display("FAIL bp_drop: got drop_cnt=%0d model=%0d, required 2", drop_cnt, exp_drop);
    end
    ev_ready = 1'b1;
    drive_commit(1'b1, I_TAIL8, CL_TAIL, 32'h1100, 32'h2100);
    wait_drain();
    n_checks++;
    if (drop_cnt !== 16'd2) begin
      n_errors++;
      $display("FAIL bp_full_pushpop: got drop_cnt=%0d, required 2", drop_cnt);
    end
  endtask

  task automatic test_alt_link();
    ev_ready = 1'b1;
    drive_commit(1'b1, I_CALL_X5, CL_CALL, 32'h3000, 32'h3100);
    @(negedge clk);
    n_checks++;
    if (ev_valid !== 1'b1 || ev_type !== 2'd0 || ev_depth !== 3'd1 || d1_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL alt_link: got alt1 valid=%0b type=%0d depth=%0d alt0 valid=%0b, required 1 0 1 0",
               ev_valid, ev_type, ev_depth, d1_valid);
    end
    @(posedge clk);
    #1;
    wait_drain();
  endtask

  // Random mix at one commit per cycle with random backpressure.
  task automatic test_back_to_back();
    logic [31:0] insts [8];
    int          cls   [8];
    logic [31:0] pc, dnpc;
    int          k;
    insts = '{32'h000000EF, 32'h000280E7, 32'h000002EF, 32'h00008067,
              32'h00028067, 32'h00408067, 32'h0000006F, 32'h000090E7};
    cls   = '{CL_CALL, CL_CALL, CL_CALL, CL_RET, CL_RET, CL_TAIL, CL_IGN, CL_IGN};
    for (int i = 0; i < 300; i++) begin
      k        = $urandom_range(7, 0);
      pc       = {$urandom_range(255, 0), 2'b00} + 32'h4000;
      dnpc     = $urandom();
      if (cls[k] == CL_RET && mstack.size() != 0 && $urandom_range(1, 0) == 1)
        dnpc = mstack[mstack.size() - 1];
      ev_ready = ($urandom_range(9, 0) < 6);
      drive_commit($urandom_range(7, 0) != 0, insts[k], cls[k], pc, dnpc);
    end
    wait_drain();
    n_checks++;
    if (sticky_ovf !== m_ovf || sticky_udf !== m_udf || drop_cnt !== 16'(exp_drop)) begin
      n_errors++;
      $display("FAIL b2b_status: got ovf=%0b udf=%0b drop=%0d, required ovf=%0b udf=%0b drop=%0d",
               sticky_ovf, sticky_udf, drop_cnt, m_ovf, m_udf, exp_drop);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_underflow();
    test_reset();
    test_call_ret();
    test_reset();
    test_overflow();
    test_reset();
    test_backpressure();
    test_reset();
    test_alt_link();
    test_reset();
    test_back_to_back();
    // Reset in the middle of a backed-up FIFO discards everything.
    ev_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_commit(1'b1, I_TAIL8, CL_TAIL, 32'h5000, 32'h6000);
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
